// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields and register-file operands,
// folds in a same-cycle write-back, and inserts load-use bubbles.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd_addr,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [7:0]       id_ctrl,
    input  logic [XLEN-1:0]  rs1_rdata,
    input  logic [XLEN-1:0]  rs2_rdata,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd_addr,
    input  logic [XLEN-1:0]  wb_wdata,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             load_use_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [4:0]       ex_rs1_addr,
    output logic [4:0]       ex_rs2_addr,
    output logic [4:0]       ex_rd_addr,
    output logic [7:0]       ex_ctrl,
    output logic [CNT_W-1:0] bubble_count
);

    localparam int CTRL_MEM_READ = 6;

    logic             ex_valid_q,     ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q,        ex_pc_d;
    logic [XLEN-1:0]  ex_imm_q,       ex_imm_d;
    logic [XLEN-1:0]  ex_rs1_data_q,  ex_rs1_data_d;
    logic [XLEN-1:0]  ex_rs2_data_q,  ex_rs2_data_d;
    logic [4:0]       ex_rs1_addr_q,  ex_rs1_addr_d;
    logic [4:0]       ex_rs2_addr_q,  ex_rs2_addr_d;
    logic [4:0]       ex_rd_addr_q,   ex_rd_addr_d;
    logic [7:0]       ex_ctrl_q,      ex_ctrl_d;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

    logic [XLEN-1:0] rf_rdata [2];
    logic [4:0]      rs_addr  [2];
    logic [XLEN-1:0] op       [2];

    assign rf_rdata[0] = rs1_rdata;
    assign rf_rdata[1] = rs2_rdata;
    assign rs_addr[0]  = id_rs1_addr;
    assign rs_addr[1]  = id_rs2_addr;

    // The register file write lands on the same edge we capture, so forward it here.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
        assign op[gi] = (wb_we && (wb_rd_addr != 5'd0) && (wb_rd_addr == rs_addr[gi]))
                        ? wb_wdata : rf_rdata[gi];
    end

    logic rs1_hit, rs2_hit;
    assign rs1_hit = id_rs1_used && (id_rs1_addr == ex_rd_addr_q);
    assign rs2_hit = id_rs2_used && (id_rs2_addr == ex_rd_addr_q);

    assign load_use_stall = ex_valid_q && ex_ctrl_q[CTRL_MEM_READ] && (ex_rd_addr_q != 5'd0)
                            && id_valid && (rs1_hit || rs2_hit);

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_pc_d        = ex_pc_q;
        ex_imm_d       = ex_imm_q;
        ex_rs1_data_d  = ex_rs1_data_q;
        ex_rs2_data_d  = ex_rs2_data_q;
        ex_rs1_addr_d  = ex_rs1_addr_q;
        ex_rs2_addr_d  = ex_rs2_addr_q;
        ex_rd_addr_d   = ex_rd_addr_q;
        ex_ctrl_d      = ex_ctrl_q;
        bubble_count_d = bubble_count_q;

        if (flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = 8'd0;
        end else if (ex_hold) begin
            ex_valid_d = ex_valid_q;
        end else if (load_use_stall) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = 8'd0;
            if (bubble_count_q != {CNT_W{1'b1}}) begin
                bubble_count_d = bubble_count_q + CNT_W'(1);
            end
        end else begin
            ex_valid_d    = id_valid;
            ex_ctrl_d     = id_valid ? id_ctrl : 8'd0;
            ex_pc_d       = id_pc;
            ex_imm_d      = id_imm;
            ex_rs1_data_d = op[0];
            ex_rs2_data_d = op[1];
            ex_rs1_addr_d = id_rs1_addr;
            ex_rs2_addr_d = id_rs2_addr;
            ex_rd_addr_d  = id_rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_imm_q       <= '0;
            ex_rs1_data_q  <= '0;
            ex_rs2_data_q  <= '0;
            ex_rs1_addr_q  <= '0;
            ex_rs2_addr_q  <= '0;
            ex_rd_addr_q   <= '0;
            ex_ctrl_q      <= '0;
            bubble_count_q <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_imm_q       <= ex_imm_d;
            ex_rs1_data_q  <= ex_rs1_data_d;
            ex_rs2_data_q  <= ex_rs2_data_d;
            ex_rs1_addr_q  <= ex_rs1_addr_d;
            ex_rs2_addr_q  <= ex_rs2_addr_d;
            ex_rd_addr_q   <= ex_rd_addr_d;
            ex_ctrl_q      <= ex_ctrl_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_imm       = ex_imm_q;
    assign ex_rs1_data  = ex_rs1_data_q;
    assign ex_rs2_data  = ex_rs2_data_q;
    assign ex_rs1_addr  = ex_rs1_addr_q;
    assign ex_rs2_addr  = ex_rs2_addr_q;
    assign ex_rd_addr   = ex_rd_addr_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly downstream of the register file.
- Captures decoded fields and the rs1/rs2 read data each cycle for the EX stage.
- Bypasses a same-cycle write-back into the captured operands.
- Detects load-use hazards and inserts bubbles; honours branch flush and downstream hold.
- Keeps a saturating bubble counter for performance monitoring.

Parameters:
XLEN, 32, datapath width
CNT_W, 16, width of bubble counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
id_valid  input  1  decode slot holds a real instruction
id_pc  input  XLEN  PC of decoded instruction
id_rs1_addr  input  5  source reg 1 (also drives register file)
id_rs2_addr  input  5  source reg 2
id_rs1_used  input  1  instruction reads rs1
id_rs2_used  input  1  instruction reads rs2
id_rd_addr  input  5  destination reg
id_imm  input  XLEN  sign-extended immediate
id_ctrl  input  8  {reg_write, mem_read, mem_write, alu_src, alu_op[3:0]}
rs1_rdata  input  XLEN  register file read port 1
rs2_rdata  input  XLEN  register file read port 2
wb_we  input  1  write-back enable (same signal feeding register file we)
wb_rd_addr  input  5  write-back destination
wb_wdata  input  XLEN  write-back data
flush  input  1  branch/jump taken in EX; kill ID instruction
ex_hold  input  1  EX cannot accept; freeze this register
load_use_stall  output  1  combinational; upstream must freeze PC and IF/ID
ex_valid  output  1  EX slot valid
ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  output  XLEN each  registered operands
ex_rs1_addr, ex_rs2_addr, ex_rd_addr  output  5 each  registered addresses
ex_ctrl  output  8  registered control
bubble_count  output  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (rst_n low at a rising edge): all outputs and registers go to 0, including bubble_count. A zeroed ex_ctrl means no reg_write/mem access. Reset overrides every other input, including mid-hold or mid-stall.
- WB bypass (combinational):
  - op1 = wb_wdata if wb_we && wb_rd_addr==id_rs1_addr && wb_rd_addr!=0; otherwise rs1_rdata. op2 is formed the same way.
  - Needed because register file writes land at the same edge as this capture.
  - Address 0 always yields rs*_rdata (the file returns 0).
- Load-use detect (combinational):
  - load_use_stall = ex_valid && ex_ctrl.mem_read && ex_rd_addr!=0 && id_valid && ((id_rs1_used && id_rs1_addr==ex_rd_addr) || (id_rs2_used && id_rs2_addr==ex_rd_addr)).
  - It is asserted regardless of flush or ex_hold; upstream gates it.
- Update priority at each rising edge (rst_n high), highest first:
  1. flush: ex_valid<=0, ex_ctrl<=0; other fields don't-care (hold them). bubble_count unchanged.
  2. ex_hold: all registers keep their value.
  3. load_use_stall: bubble, i.e. ex_valid<=0, ex_ctrl<=0. bubble_count+1, saturating at all-ones.
  4. otherwise capture: ex_valid<=id_valid, ex_ctrl<=(id_valid ? id_ctrl : 0), ex_rs1_data<=op1, ex_rs2_data<=op2, and all other fields copied.
- Latency: 1 cycle ID to EX. No combinational path from id_* to ex_*.
- After a bubble, the stalled instruction is presented again by upstream. On the next edge the load has moved past EX, so the stall deasserts and capture proceeds. The MEM->EX forward is EX's responsibility.
- Invalid ID slot (id_valid=0) never asserts stall and never counts a bubble.
- bubble_count only increments in case 3, and never wraps.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with id_valid=1 and junk inputs -> all ex_* =0 and bubble_count=0; the next edge with rst_n=1 captures normally.
- Normal capture: id_pc=0x100, rs1=5 (rdata 0xAAAA), rs2=6 (rdata 0x5555), rd=7, ctrl=0x81 -> one cycle later ex_pc=0x100, ex_rs1_data=0xAAAA, ex_rs2_data=0x5555, ex_ctrl=0x81, ex_valid=1.
- WB bypass: wb_we=1, wb_rd=5, wb_wdata=0x1234 while rs1_rdata=0xAAAA and id_rs1=5 -> ex_rs1_data=0x1234. Repeat with wb_rd=0 and id_rs1=0 -> ex_rs1_data=rs1_rdata(0).
- Load-use: EX holds lw x3 (mem_read=1), ID add reads x3 via rs2 -> load_use_stall=1, next ex_valid=0, ex_ctrl=0, bubble_count=1. The following cycle the add is captured with stall=0. Same case with id_rs2_used=0 -> no stall.
- Priority: flush=1 and ex_hold=1 together with a load-use condition -> ex_valid=0, bubble_count unchanged. ex_hold=1 alone with a load-use condition -> all ex_* unchanged, count unchanged.
- Saturation: CNT_W=4, force 20 consecutive load-use bubbles -> bubble_count stops at 15.
